// File: rtl/serial_unload_reg_pkg.sv
// Shared definitions for the serial unload register: FSM state encoding.
// Defining SERIAL_UNLOAD_PARITY_EN adds one even-parity bit cycle after the data bits.
package serial_unload_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_unload_reg.sv
// Parallel-in, serial-out transmit register: captures D on Start, shifts it out LSB first.
// Optional macro SERIAL_UNLOAD_PARITY_EN appends an even-parity bit before Done.
module serial_unload_reg
    import serial_unload_reg_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic         CLK,
    input  logic         Resetn,
    input  logic [W-1:0] D,
    input  logic         Start,
    output logic         SerOut,
    output logic         Busy,
    output logic         Done
);

    localparam int unsigned CW = $clog2(W + 1);

    // Count value on which the final SHIFT cycle ends and DONE follows.
`ifdef SERIAL_UNLOAD_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(W);
`else
    localparam logic [CW-1:0] LAST = CW'(W - 1);
`endif

    state_e        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] count_q, count_d;
    logic          serout_q, serout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_ff @(posedge CLK) begin
        if (!Resetn) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            count_q  <= '0;
            serout_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            count_q  <= count_d;
            serout_q <= serout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Start) state_d = ST_SHIFT;
            ST_SHIFT: if (count_q == LAST) state_d = ST_DONE;
            ST_DONE:  state_d = Start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shreg_d  = shreg_q;
        count_d  = count_q;
        serout_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    shreg_d  = D;
                    serout_d = D[0];
                    busy_d   = 1'b1;
                    count_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (count_q == LAST) begin
                    done_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                    busy_d  = 1'b1;
                    for (int unsigned i = 0; i < W; i++) begin
                        if (count_d == CW'(i)) serout_d = shreg_q[i];
                    end
`ifdef SERIAL_UNLOAD_PARITY_EN
                    if (count_q == CW'(W - 1)) serout_d = ^shreg_q;
`endif
                end
            end
            default: ;
        endcase
    end

    assign SerOut = serout_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_serial_unload_reg.sv
// Self-checking bench for serial_unload_reg: directed scenarios then random traffic
// against a per-word expected-output queue. Honours SERIAL_UNLOAD_PARITY_EN.
module tb_serial_unload_reg;

    localparam int unsigned W = 3;

    logic         CLK = 1'b0;
    logic         Resetn;
    logic         Start;
    logic [W-1:0] D;
    logic         SerOut;
    logic         Busy;
    logic         Done;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    typedef struct packed {
        logic ser;
        logic busy;
        logic done;
    } out_t;

    out_t exp_q[$];
    out_t cur = '0;

    serial_unload_reg #(.W(W)) dut (
        .CLK   (CLK),
        .Resetn(Resetn),
        .D     (D),
        .Start (Start),
        .SerOut(SerOut),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 CLK = ~CLK;

    // One clock edge: apply inputs, advance the model, check outputs just after the edge.
    task automatic edge_step(input logic rstn, input logic st, input logic [W-1:0] d);
        out_t e;
        Resetn = rstn;
        Start  = st;
        D      = d;
        @(posedge CLK);
        if (!rstn) begin
            exp_q.delete();
            cur = '0;
        end else begin
            // A word is accepted whenever the transmitter is not busy.
            if (!cur.busy && st) begin
                exp_q.delete();
                for (int i = 0; i < W; i++) begin
                    e = '{ser: d[i], busy: 1'b1, done: 1'b0};
                    exp_q.push_back(e);
                end
`ifdef SERIAL_UNLOAD_PARITY_EN
                e = '{ser: ^d, busy: 1'b1, done: 1'b0};
                exp_q.push_back(e);
`endif
                e = '{ser: 1'b0, busy: 1'b0, done: 1'b1};
                exp_q.push_back(e);
            end
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : out_t'('0);
        end
        #1;
        compared++;
        assert (SerOut === cur.ser) else begin
            mismatched++;
            $error("FAIL serout: observed %b expected %b at %0t", SerOut, cur.ser, $time);
        end
        compared++;
        assert (Busy === cur.busy) else begin
            mismatched++;
            $error("FAIL busy: observed %b expected %b at %0t", Busy, cur.busy, $time);
        end
        compared++;
        assert (Done === cur.done) else begin
            mismatched++;
            $error("FAIL done: observed %b expected %b at %0t", Done, cur.done, $time);
        end
    endtask

    initial begin
        Resetn = 1'b0;
        Start  = 1'b0;
        D      = '0;

        // Reset held with Start asserted must keep everything quiet.
        edge_step(1'b0, 1'b1, 3'b111);
        edge_step(1'b0, 1'b1, 3'b111);
        edge_step(1'b1, 1'b0, 3'b000);

        // Single word 101.
        edge_step(1'b1, 1'b1, 3'b101);
        repeat (5) edge_step(1'b1, 1'b0, 3'b000);

        // Word 110 with Start/D changes during the shift.
        edge_step(1'b1, 1'b1, 3'b110);
        edge_step(1'b1, 1'b1, 3'b001);
        edge_step(1'b1, 1'b1, 3'b001);
        repeat (4) edge_step(1'b1, 1'b0, 3'b000);

        // Start held high: back-to-back words with a one-cycle Done gap.
        repeat (12) edge_step(1'b1, 1'b1, 3'b011);
        repeat (5) edge_step(1'b1, 1'b0, 3'b000);

        // Reset mid-word aborts without Done, then a normal word.
        edge_step(1'b1, 1'b1, 3'b101);
        edge_step(1'b1, 1'b0, 3'b000);
        edge_step(1'b0, 1'b0, 3'b000);
        edge_step(1'b1, 1'b0, 3'b000);
        edge_step(1'b1, 1'b1, 3'b101);
        repeat (5) edge_step(1'b1, 1'b0, 3'b000);

        // Parity-1 word.
        edge_step(1'b1, 1'b1, 3'b100);
        repeat (5) edge_step(1'b1, 1'b0, 3'b000);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            edge_step(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)), W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_unload_reg.md
Name: serial_unload_reg

Overview:
- Parallel-in, serial-out transmit register: the unload/read end of the parallel-load register path.
- Captures a W-bit word on a Start pulse and shifts it out LSB-first on SerOut, one bit per clock.
- Busy and Done flags provide a handshake to the controlling FSM.
- Sits between a loaded register bank and any serial consumer in the register-transfer datapath.

Parameters:
- W, 3, data word width in bits (W >= 1).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Resetn  input  1  synchronous active-low reset, sampled on the CLK rising edge.
- D  input  W  parallel word to transmit; sampled only when Start is accepted.
- Start  input  1  request to capture D and begin shifting.
- SerOut  output  1  serial data bit, LSB first; 0 when not transmitting.
- Busy  output  1  high while bits are being driven on SerOut.
- Done  output  1  single-cycle pulse after the last bit.

Behaviour:
- Reset: any rising CLK edge with Resetn=0 forces state=IDLE, SerOut=0, Busy=0, Done=0, shift register=0, count=0. Reset takes priority over Start and aborts an in-flight word with no Done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE, Start=1 at edge k:
  - shreg<=D; SerOut<=D[0]; Busy<=1; count<=0; go to SHIFT.
- IDLE, Start=0: all outputs hold 0.
- SHIFT, each edge, count<W-1:
  - SerOut<=shreg[count+1]; count<=count+1.
- SHIFT, each edge, count==W-1:
  - SerOut<=0; Busy<=0; Done<=1; go to DONE.
- Resulting timing: SerOut=D[i] during the cycle after edge k+i (i=0..W-1). Done is high for exactly the cycle after edge k+W. Busy is high for exactly W cycles.
- DONE, one cycle only:
  - Done<=0 at the next edge.
  - If Start=1, the new word is accepted exactly as from IDLE, giving back-to-back words with a one-cycle gap.
  - Otherwise go to IDLE.
- Start while in SHIFT is ignored; the word and D changes do not affect the transfer in progress.
- D is sampled only on the accepting edge.
- W=1: SHIFT lasts one cycle; Done follows at edge k+1.
- count width: clog2(W+1) bits, so it holds W without overflow. No wrap-around occurs because count is cleared on every accept.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_UNLOAD_PARITY_EN.
- Defined:
  - After D[W-1], one extra cycle drives the even-parity bit (XOR of all captured bits) on SerOut with Busy=1.
  - Busy is high for W+1 cycles; Done is high in the cycle after edge k+W+1.
  - count must reach W before the transition to DONE.
- Not defined:
  - No parity cycle; timing exactly as in Behaviour. No parity logic is synthesized.

Decomposition:
- Shared package/include, serial_unload_defs:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - The parity-cycle enable note.
- No sub-module is needed. Optionally, a parity_gen (XOR-reduce of W bits) may be instantiated under the macro.

Test Plan (W=3, macro undefined unless stated):
- Resetn=0 for 2 cycles with Start=1, D=3'b111 -> SerOut=0, Busy=0, Done=0 throughout reset.
- D=3'b101, Start pulsed at edge k -> SerOut 1,0,1 in the cycles after edges k, k+1, k+2; Busy=1 for those 3 cycles; Done=1 only after edge k+3.
- D=3'b110 accepted, then Start=1 and D=3'b001 during SHIFT -> SerOut remains 0,1,1; the second request is ignored; a single Done pulse.
- Start held high continuously with D=3'b011 -> words repeat with SerOut 1,1,0, then a Done gap cycle with SerOut=0, then 1,1,0 again.
- Resetn=0 at the edge after the second bit of D=3'b101 -> next cycle SerOut=0, Busy=0, no Done pulse; a Start afterwards transmits normally.
- Macro defined, D=3'b101 -> SerOut 1,0,1,0 (parity 0), Busy for 4 cycles, Done after edge k+4. With D=3'b100 the parity bit is 1.
